// File: rtl/mastermind_scorer.sv
// rtl/mastermind_scorer.sv - serial Znarly/Zood guess scorer with guess count and win/game-over tracking
// One slot compare per cycle: SLOTS exact-position passes, then SLOTS*SLOTS cross-slot pairs.
module mastermind_scorer #(
    parameter int SLOTS       = 4,
    parameter int SHAPE_W     = 3,
    parameter int MAX_GUESSES = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               newGame,
    input  logic                               loadMaster,
    input  logic [SLOTS*SHAPE_W-1:0]           masterIn,
    input  logic                               check,
    input  logic [SLOTS*SHAPE_W-1:0]           guess,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(SLOTS+1)-1:0]         znarly,
    output logic [$clog2(SLOTS+1)-1:0]         zood,
    output logic [$clog2(MAX_GUESSES+1)-1:0]   guessCount,
    output logic                               win,
    output logic                               gameOver
);
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int SCR_W = $clog2(SLOTS + 1);
    localparam int CNT_W = $clog2(MAX_GUESSES + 1);
    localparam int PAT_W = SLOTS * SHAPE_W;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SLOTS - 1);
    localparam logic [SCR_W-1:0] FULL_SCORE = SCR_W'(SLOTS);
    localparam logic [CNT_W-1:0] MAX_COUNT  = CNT_W'(MAX_GUESSES);

    typedef enum logic [1:0] {S_IDLE, S_EXACT, S_PARTIAL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   master_q, master_d;
    logic [PAT_W-1:0]   guess_q, guess_d;
    logic [SLOTS-1:0]   gused_q, gused_d;
    logic [SLOTS-1:0]   mused_q, mused_d;
    logic [SCR_W-1:0]   zacc_q, zacc_d;
    logic [SCR_W-1:0]   oacc_q, oacc_d;
    logic [IDX_W-1:0]   gi_q, gi_d;
    logic [IDX_W-1:0]   mi_q, mi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SCR_W-1:0]   znarly_q, znarly_d;
    logic [SCR_W-1:0]   zood_q, zood_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               win_q, win_d;
    logic               over_q, over_d;

    logic [SHAPE_W-1:0] g_shape;
    logic [SHAPE_W-1:0] m_shape;
    logic [SHAPE_W-1:0] x_shape;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            master_q <= '0;
            guess_q  <= '0;
            gused_q  <= '0;
            mused_q  <= '0;
            zacc_q   <= '0;
            oacc_q   <= '0;
            gi_q     <= '0;
            mi_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            znarly_q <= '0;
            zood_q   <= '0;
            count_q  <= '0;
            win_q    <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            master_q <= master_d;
            guess_q  <= guess_d;
            gused_q  <= gused_d;
            mused_q  <= mused_d;
            zacc_q   <= zacc_d;
            oacc_q   <= oacc_d;
            gi_q     <= gi_d;
            mi_q     <= mi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            znarly_q <= znarly_d;
            zood_q   <= zood_d;
            count_q  <= count_d;
            win_q    <= win_d;
            over_q   <= over_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        master_d = master_q;
        guess_d  = guess_q;
        gused_d  = gused_q;
        mused_d  = mused_q;
        zacc_d   = zacc_q;
        oacc_d   = oacc_q;
        gi_d     = gi_q;
        mi_d     = mi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        znarly_d = znarly_q;
        zood_d   = zood_q;
        count_d  = count_q;
        win_d    = win_q;
        over_d   = over_q;
        g_shape  = guess_q[gi_q*SHAPE_W +: SHAPE_W];
        m_shape  = master_q[mi_q*SHAPE_W +: SHAPE_W];
        x_shape  = master_q[gi_q*SHAPE_W +: SHAPE_W];

        // A load in IDLE lands on the same edge as an accepted check, so scoring sees the new master.
        if (state_q == S_IDLE && loadMaster) begin
            master_d = masterIn;
        end

        if (newGame) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            count_d = '0;
            win_d   = 1'b0;
            over_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (check && !over_q) begin
                        state_d = S_EXACT;
                        guess_d = guess;
                        gused_d = '0;
                        mused_d = '0;
                        zacc_d  = '0;
                        oacc_d  = '0;
                        gi_d    = '0;
                        mi_d    = '0;
                        busy_d  = 1'b1;
                    end
                end
                S_EXACT: begin
                    if (g_shape == x_shape) begin
                        zacc_d        = zacc_q + 1'b1;
                        gused_d[gi_q] = 1'b1;
                        mused_d[gi_q] = 1'b1;
                    end
                    if (gi_q == LAST_IDX) begin
                        state_d = S_PARTIAL;
                        gi_d    = '0;
                        mi_d    = '0;
                    end else begin
                        gi_d = gi_q + 1'b1;
                    end
                end
                S_PARTIAL: begin
                    // Used bits are registered, so a slot claimed on this pair is skipped from the next pair on.
                    if (gi_q != mi_q && !gused_q[gi_q] && !mused_q[mi_q] && g_shape == m_shape) begin
                        oacc_d        = oacc_q + 1'b1;
                        gused_d[gi_q] = 1'b1;
                        mused_d[mi_q] = 1'b1;
                    end
                    if (mi_q == LAST_IDX) begin
                        mi_d = '0;
                        if (gi_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            gi_d = gi_q + 1'b1;
                        end
                    end else begin
                        mi_d = mi_q + 1'b1;
                    end
                end
                S_DONE: begin
                    znarly_d = zacc_q;
                    zood_d   = oacc_q;
                    done_d   = 1'b1;
                    if (count_q != MAX_COUNT) begin
                        count_d = count_q + 1'b1;
                    end
                    win_d   = (zacc_q == FULL_SCORE);
                    over_d  = win_d || (count_d == MAX_COUNT);
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign znarly     = znarly_q;
    assign zood       = zood_q;
    assign guessCount = count_q;
    assign win        = win_q;
    assign gameOver   = over_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// tb/tb_mastermind_scorer.sv - scoreboard bench for mastermind_scorer (default and MAX_GUESSES=2 instances)
module tb_mastermind_scorer;
    localparam int W = 12;
    localparam logic [W-1:0] M_A   = 12'b001010011100;
    localparam logic [W-1:0] G_REV = 12'b100011010001;
    localparam logic [W-1:0] G_ONE = 12'b001001001001;
    localparam logic [W-1:0] G_3X  = 12'b011001001001;
    localparam logic [W-1:0] G_12  = 12'b010001100100;

    typedef struct { int z; int o; int c; int w; int go; } exp_t;
    typedef struct { int busy; int done; int z; int o; int c; int w; int go; } obs_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]   rst_v, ng_v, ld_v, ck_v;
    logic [W-1:0] mi_v [2];
    logic [W-1:0] gi_v [2];

    logic       busy0, done0, win0, over0, busy1, done1, win1, over1;
    logic [2:0] zn0, zo0, zn1, zo1;
    logic [3:0] cnt0;
    logic [1:0] cnt1;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    mastermind_scorer dut0 (
        .clock(clock), .reset(rst_v[0]), .newGame(ng_v[0]), .loadMaster(ld_v[0]),
        .masterIn(mi_v[0]), .check(ck_v[0]), .guess(gi_v[0]), .busy(busy0), .done(done0),
        .znarly(zn0), .zood(zo0), .guessCount(cnt0), .win(win0), .gameOver(over0)
    );

    mastermind_scorer #(.MAX_GUESSES(2)) dut1 (
        .clock(clock), .reset(rst_v[1]), .newGame(ng_v[1]), .loadMaster(ld_v[1]),
        .masterIn(mi_v[1]), .check(ck_v[1]), .guess(gi_v[1]), .busy(busy1), .done(done1),
        .znarly(zn1), .zood(zo1), .guessCount(cnt1), .win(win1), .gameOver(over1)
    );

    function automatic obs_t obs(input int d);
        obs_t r;
        if (d == 0) begin
            r.busy = busy0; r.done = done0; r.z = zn0; r.o = zo0; r.c = cnt0; r.w = win0; r.go = over0;
        end else begin
            r.busy = busy1; r.done = done1; r.z = zn1; r.o = zo1; r.c = cnt1; r.w = win1; r.go = over1;
        end
        return r;
    endfunction

    function automatic exp_t mk(input int z, input int o, input int c, input int w, input int go);
        exp_t e;
        e.z = z; e.o = o; e.c = c; e.w = w; e.go = go;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_done(input int d, input obs_t r);
        exp_t e;
        int   have;
        have = (d == 0) ? q0.size() : q1.size();
        chk($sformatf("dut%0d_done_expected", d), int'(have > 0), 1);
        if (have > 0) begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("dut%0d_znarly", d), r.z, e.z);
            chk($sformatf("dut%0d_zood", d), r.o, e.o);
            chk($sformatf("dut%0d_guessCount", d), r.c, e.c);
            chk($sformatf("dut%0d_win", d), r.w, e.w);
            chk($sformatf("dut%0d_gameOver", d), r.go, e.go);
            chk($sformatf("dut%0d_busy_low_at_done", d), r.busy, 0);
        end
    endtask

    initial begin
        obs_t r;
        forever begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                r = obs(d);
                if (r.done != 0) check_done(d, r);
            end
        end
    end

    task automatic drive(input int d, input logic ng, input logic ld, input logic [W-1:0] m,
                         input logic ck, input logic [W-1:0] g);
        @(negedge clock);
        ng_v[d] = ng; ld_v[d] = ld; mi_v[d] = m; ck_v[d] = ck; gi_v[d] = g;
        @(posedge clock);
        #1;
        ng_v[d] = 1'b0; ld_v[d] = 1'b0; ck_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int limit, output int n);
        obs_t r;
        n = 0;
        r = obs(d);
        while (r.done == 0 && n < limit) begin
            @(posedge clock);
            #1;
            n++;
            r = obs(d);
        end
    endtask

    task automatic score(input int d, input logic ld, input logic [W-1:0] m,
                         input logic [W-1:0] g, input exp_t e);
        obs_t r;
        int   n;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        drive(d, 1'b0, ld, m, 1'b1, g);
        r = obs(d);
        chk("busy_after_accept", r.busy, 1);
        wait_done(d, 100, n);
        chk("latency_edges", n, 21);
    endtask

    task automatic watch_idle(input int d, input int cycles, input string name);
        obs_t r;
        int   seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clock);
            #1;
            r = obs(d);
            if (r.busy != 0) seen = 1;
        end
        chk(name, seen, 0);
    endtask

    task automatic expect_all_zero(input int d, input string tag);
        obs_t r;
        r = obs(d);
        chk({tag, "_busy"}, r.busy, 0);
        chk({tag, "_done"}, r.done, 0);
        chk({tag, "_znarly"}, r.z, 0);
        chk({tag, "_zood"}, r.o, 0);
        chk({tag, "_count"}, r.c, 0);
        chk({tag, "_win"}, r.w, 0);
        chk({tag, "_gameOver"}, r.go, 0);
    endtask

    initial begin
        obs_t r;
        int   n;
        rst_v = 2'b11; ng_v = '0; ld_v = '0; ck_v = '0;
        mi_v[0] = '0; mi_v[1] = '0; gi_v[0] = '0; gi_v[1] = '0;
        #12;
        expect_all_zero(0, "reset0");
        expect_all_zero(1, "reset1");
        @(negedge clock);
        rst_v = 2'b00;

        drive(0, 1'b0, 1'b1, M_A, 1'b0, '0);
        drive(1, 1'b0, 1'b1, M_A, 1'b0, '0);

        score(0, 1'b0, '0, M_A, mk(4, 0, 1, 1, 1));
        drive(0, 1'b0, 1'b0, '0, 1'b1, G_REV);
        watch_idle(0, 25, "check_ignored_after_win");
        drive(0, 1'b1, 1'b0, '0, 1'b0, '0);
        r = obs(0);
        chk("newgame_win", r.w, 0);
        chk("newgame_gameOver", r.go, 0);
        chk("newgame_count", r.c, 0);
        chk("newgame_znarly_holds", r.z, 4);

        score(0, 1'b0, '0, G_REV, mk(0, 4, 1, 0, 0));
        score(0, 1'b0, '0, G_ONE, mk(1, 0, 2, 0, 0));
        score(0, 1'b1, G_ONE, G_3X, mk(3, 0, 3, 0, 0));
        drive(0, 1'b0, 1'b1, M_A, 1'b0, '0);
        score(0, 1'b0, '0, G_12, mk(1, 2, 4, 0, 0));

        q0.push_back(mk(0, 4, 5, 0, 0));
        drive(0, 1'b0, 1'b0, '0, 1'b1, G_REV);
        repeat (4) @(posedge clock);
        drive(0, 1'b0, 1'b0, '0, 1'b1, M_A);
        wait_done(0, 40, n);
        r = obs(0);
        chk("repulse_done_seen", r.done, 1);
        watch_idle(0, 30, "repulse_no_second_op");

        drive(0, 1'b0, 1'b0, '0, 1'b1, G_12);
        repeat (9) @(posedge clock);
        drive(0, 1'b1, 1'b0, '0, 1'b0, '0);
        r = obs(0);
        chk("abort_busy", r.busy, 0);
        chk("abort_count", r.c, 0);
        chk("abort_gameOver", r.go, 0);
        watch_idle(0, 30, "abort_no_restart");
        r = obs(0);
        chk("abort_znarly_holds", r.z, 0);
        chk("abort_zood_holds", r.o, 4);

        score(1, 1'b0, '0, G_REV, mk(0, 4, 1, 0, 0));
        score(1, 1'b0, '0, G_ONE, mk(1, 0, 2, 0, 1));
        drive(1, 1'b0, 1'b0, '0, 1'b1, M_A);
        watch_idle(1, 25, "check_ignored_at_max");
        r = obs(1);
        chk("max_gameOver_holds", r.go, 1);
        chk("max_count_holds", r.c, 2);
        drive(1, 1'b1, 1'b0, '0, 1'b0, '0);
        r = obs(1);
        chk("max_newgame_gameOver", r.go, 0);
        chk("max_newgame_count", r.c, 0);
        chk("max_newgame_znarly_holds", r.z, 1);
        score(1, 1'b0, '0, G_12, mk(1, 2, 1, 0, 0));

        drive(1, 1'b0, 1'b0, '0, 1'b1, G_REV);
        repeat (9) @(posedge clock);
        @(negedge clock);
        rst_v[1] = 1'b1;
        #1;
        expect_all_zero(1, "midreset");
        @(negedge clock);
        rst_v[1] = 1'b0;
        watch_idle(1, 30, "reset_no_resume");
        score(1, 1'b0, '0, '0, mk(4, 0, 1, 1, 1));

        repeat (3) @(posedge clock);
        chk("dut0_pending_results", q0.size(), 0);
        chk("dut1_pending_results", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

endmodule
